// File: rtl/iob_merge_rr_if.sv
// Bundled IOb merger ports: N_MASTERS request/response slices plus the shared slave port.
// The slave modport is the merger's own view; the master modport is the surrounding system's view.
interface iob_merge_rr_if #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;

    // Request slice {valid, addr, wdata, wstrb}, response slice {rdata, ready}; master 0 in the LSBs.
    logic [N_MASTERS*REQ_W-1:0]  m_req;
    logic [N_MASTERS*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]            s_req;
    logic [RESP_W-1:0]           s_resp;
    logic                        busy;

    modport slave (
        input  m_req,
        input  s_resp,
        output m_resp,
        output s_req,
        output busy
    );

    modport master (
        output m_req,
        output s_resp,
        input  m_resp,
        input  s_req,
        input  busy
    );
endinterface

// File: rtl/iob_merge_rr.sv
// Round-robin merger of N_MASTERS IOb native masters onto one slave, one transaction outstanding.
// Define IOB_MERGE_RR_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module iob_merge_rr #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input logic           clk,
    input logic           rst_n,
    iob_merge_rr_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int RESP_W = DATA_W + 1;
    localparam int PTR_W  = $clog2(N_MASTERS);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]           state;
    logic [PTR_W-1:0]     gnt;
    logic [PTR_W-1:0]     scan_base;
    logic [PTR_W-1:0]     winner;
    logic                 any_valid;
    logic                 s_ready;
    logic [REQ_W-1:0]     s_req_q;
    logic [REQ_W-1:0]     req_arr [N_MASTERS];
    logic [N_MASTERS-1:0] m_valid;

    // Modular add for indices below N_MASTERS; one subtraction covers every caller's range.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_MASTERS) sum = sum - N_MASTERS;
        return PTR_W'(sum);
    endfunction

    assign s_ready = bus.s_resp[0];

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_port
        assign req_arr[i] = bus.m_req[i*REQ_W +: REQ_W];
        assign m_valid[i] = req_arr[i][REQ_W-1];
        // Only the granted slice ever carries the slave response, and only while BUSY.
        assign bus.m_resp[i*RESP_W +: RESP_W] =
            (state == BUSY && s_ready && gnt == PTR_W'(i)) ? bus.s_resp : '0;
    end

`ifdef IOB_MERGE_RR_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [PTR_W-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == BUSY && s_ready) begin
            ptr <= wrap_inc(gnt, 1);
        end
    end

    assign scan_base = ptr;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!any_valid && m_valid[wrap_inc(scan_base, k)]) begin
                winner    = wrap_inc(scan_base, k);
                any_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            s_req_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state   <= BUSY;
                        gnt     <= winner;
                        s_req_q <= req_arr[winner];
                    end
                end
                BUSY: begin
                    // Request stays frozen until the slave completes, whatever the master does.
                    if (s_ready) begin
                        state   <= IDLE;
                        s_req_q <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_req_q <= '0;
                end
            endcase
        end
    end

    assign bus.s_req = s_req_q;
    assign bus.busy  = (state == BUSY);
endmodule

// File: tb/tb_iob_merge_rr.sv
// Self-checking bench for iob_merge_rr: vector table, directed corner sequences and a random
// run against a transaction-level arbitration model, on a 2-master and a 3-master instance.
module tb_iob_merge_rr;
    localparam int REQ_W  = 69;
    localparam int RESP_W = 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iob_merge_rr_if #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus2 ();
    iob_merge_rr_if #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32)) bus3 ();

    iob_merge_rr #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    iob_merge_rr #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    logic        v2 [2];
    logic [31:0] a2 [2];
    logic [31:0] d2 [2];
    logic [3:0]  w2 [2];
    logic        sr2;
    logic [31:0] sd2;
    logic        v3 [3];
    logic [31:0] a3 [3];
    logic [31:0] d3 [3];
    logic [3:0]  w3 [3];
    logic        sr3;
    logic [31:0] sd3;

    for (genvar i = 0; i < 2; i++) begin : g_m2
        assign bus2.m_req[i*REQ_W +: REQ_W] = {v2[i], a2[i], d2[i], w2[i]};
    end
    for (genvar i = 0; i < 3; i++) begin : g_m3
        assign bus3.m_req[i*REQ_W +: REQ_W] = {v3[i], a3[i], d3[i], w3[i]};
    end
    assign bus2.s_resp = {sd2, sr2};
    assign bus3.s_resp = {sd3, sr3};

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [68:0] rq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        return {1'b1, a, d, w};
    endfunction

    function automatic logic [32:0] rs(input logic [31:0] d);
        return {d, 1'b1};
    endfunction

    typedef struct {
        logic        v0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [3:0]  w0;
        logic        v1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [3:0]  w1;
        logic        rdy;
        logic [31:0] rdata;
        logic [68:0] e_sreq;
        logic [32:0] e_r0;
        logic [32:0] e_r1;
        logic        e_busy;
    } vec_t;

    vec_t vt [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ord [3];
        int w;
        int idx;
        logic [98:0] exp3;
        bit pend [3];
        int waited [3];
        bit out_q;
        int cur;
        int last_g;
        int lat;
        logic [68:0] cap;

        for (int i = 0; i < 2; i++) begin
            v2[i] = 1'b0; a2[i] = '0; d2[i] = '0; w2[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            v3[i] = 1'b0; a3[i] = '0; d3[i] = '0; w3[i] = '0;
        end
        sr2 = 1'b0; sd2 = '0; sr3 = 1'b0; sd3 = '0;

        // Single read m0, write pass-through m1, then a stray slave ready while idle.
        vt[0] = '{1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                  69'h0, 33'h0, 33'h0, 1'b0};
        vt[1] = '{1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                  rq(32'h100, 32'h0, 4'h0), 33'h0, 33'h0, 1'b1};
        vt[2] = vt[1];
        vt[3] = '{1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF,
                  rq(32'h100, 32'h0, 4'h0), rs(32'hDEADBEEF), 33'h0, 1'b1};
        vt[4] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                  69'h0, 33'h0, 33'h0, 1'b0};
        vt[5] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h8, 32'h12345678, 4'hF, 1'b0, 32'h0,
                  69'h0, 33'h0, 33'h0, 1'b0};
        vt[6] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h8, 32'h12345678, 4'hF, 1'b0, 32'h0,
                  rq(32'h8, 32'h12345678, 4'hF), 33'h0, 33'h0, 1'b1};
        vt[7] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h8, 32'h12345678, 4'hF, 1'b1, 32'hCAFEF00D,
                  rq(32'h8, 32'h12345678, 4'hF), 33'h0, rs(32'hCAFEF00D), 1'b1};
        vt[8] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h55555555,
                  69'h0, 33'h0, 33'h0, 1'b0};

        repeat (2) @(posedge clk);
        #4;
        check("rst_sreq2", bus2.s_req, 69'h0);
        check("rst_busy2", bus2.busy, 1'b0);
        check("rst_resp2", bus2.m_resp, 66'h0);
        check("rst_sreq3", bus3.s_req, 69'h0);
        check("rst_busy3", bus3.busy, 1'b0);
        check("rst_resp3", bus3.m_resp, 99'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vt[r]) begin
            step();
            v2[0] = vt[r].v0; a2[0] = vt[r].a0; d2[0] = vt[r].d0; w2[0] = vt[r].w0;
            v2[1] = vt[r].v1; a2[1] = vt[r].a1; d2[1] = vt[r].d1; w2[1] = vt[r].w1;
            sr2 = vt[r].rdy; sd2 = vt[r].rdata;
            #3;
            check($sformatf("vec%0d_sreq", r), bus2.s_req, vt[r].e_sreq);
            check($sformatf("vec%0d_resp0", r), bus2.m_resp[32:0], vt[r].e_r0);
            check($sformatf("vec%0d_resp1", r), bus2.m_resp[65:33], vt[r].e_r1);
            check($sformatf("vec%0d_busy", r), bus2.busy, vt[r].e_busy);
        end

        // Both masters hold valid, slave answers one cycle after s_valid rises.
        for (int t = 0; t < 4; t++) begin
`ifdef IOB_MERGE_RR_FIXED_PRIO_EN
            w = 0;
`else
            w = t % 2;
`endif
            step();
            v2[0] = 1'b1; a2[0] = 32'h1000; d2[0] = '0; w2[0] = '0;
            v2[1] = 1'b1; a2[1] = 32'h2000; d2[1] = '0; w2[1] = '0;
            sr2 = 1'b0;
            #3;
            check("simul_idle", bus2.s_req[68], 1'b0);
            step();
            #3;
            check("simul_req", bus2.s_req, rq(w == 0 ? 32'h1000 : 32'h2000, 32'h0, 4'h0));
            step();
            sr2 = 1'b1; sd2 = 32'hA000_0000 + t;
            #3;
            check("simul_win", bus2.m_resp[w*33 +: 33], rs(32'hA000_0000 + t));
            check("simul_lose", bus2.m_resp[(1-w)*33 +: 33], 33'h0);
        end

        // A granted master changing its request mid-transaction must not disturb s_req.
        step();
        v2[1] = 1'b0; v2[0] = 1'b1; a2[0] = 32'h10; sr2 = 1'b0;
        #3;
        check("stab_idle", bus2.s_req[68], 1'b0);
        step();
        a2[0] = 32'h20;
        #3;
        check("stab_hold1", bus2.s_req, rq(32'h10, 32'h0, 4'h0));
        step();
        #3;
        check("stab_hold2", bus2.s_req, rq(32'h10, 32'h0, 4'h0));
        step();
        sr2 = 1'b1; sd2 = 32'h77;
        #3;
        check("stab_hold3", bus2.s_req, rq(32'h10, 32'h0, 4'h0));
        check("stab_resp", bus2.m_resp, {33'h0, rs(32'h77)});
        step();
        v2[0] = 1'b0; sr2 = 1'b0;
        #3;
        check("stab_done", bus2.s_req, 69'h0);

        // Three masters: one m1 transaction moves the pointer to 2, then all request at once.
        step();
        v3[1] = 1'b1; a3[1] = 32'h111;
        step();
        step();
        sr3 = 1'b1; sd3 = 32'h5;
        #3;
        check("wrap_setup", bus3.m_resp, {33'h0, rs(32'h5), 33'h0});
`ifdef IOB_MERGE_RR_FIXED_PRIO_EN
        ord = '{0, 0, 0};
`else
        ord = '{2, 0, 1};
`endif
        for (int t = 0; t < 3; t++) begin
            step();
            sr3 = 1'b0;
            for (int i = 0; i < 3; i++) begin
                v3[i] = 1'b1; a3[i] = 32'h300 + i; d3[i] = '0; w3[i] = '0;
            end
            step();
            #3;
            check("wrap_req", bus3.s_req, rq(32'h300 + ord[t], 32'h0, 4'h0));
            step();
            sr3 = 1'b1; sd3 = 32'hB0 + t;
            exp3 = '0;
            exp3[ord[t]*33 +: 33] = rs(32'hB0 + t);
            #3;
            check("wrap_resp", bus3.m_resp, exp3);
        end
        step();
        for (int i = 0; i < 3; i++) v3[i] = 1'b0;
        sr3 = 1'b0;

        // Asynchronous reset while BUSY, then a late slave ready that must be dropped.
        step();
        v2[0] = 1'b1; a2[0] = 32'h40; sr2 = 1'b0;
        step();
        #3;
        check("rstmid_busy", bus2.s_req, rq(32'h40, 32'h0, 4'h0));
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_sreq", bus2.s_req, 69'h0);
        check("rstmid_bsy", bus2.busy, 1'b0);
        v2[0] = 1'b0;
        step();
        rst_n = 1'b1;
        sr2 = 1'b1; sd2 = 32'hBAD;
        #3;
        check("rstmid_resp", bus2.m_resp, 66'h0);
        check("rstmid_idle", bus2.busy, 1'b0);
        step();
        sr2 = 1'b0;
        #3;
        check("rstmid_stay", bus2.s_req, 69'h0);

        // Random traffic on the 3-master instance against a transaction-level model.
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; waited[i] = 0;
        end
        out_q = 1'b0; cur = 0; last_g = 2; lat = 0; cap = '0;
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(2) == 0) begin
                        pend[i] = 1'b1; waited[i] = 0;
                        v3[i] = 1'b1; a3[i] = {4'(i), 28'($urandom)};
                        d3[i] = $urandom; w3[i] = 4'($urandom_range(15));
                    end else begin
                        v3[i] = 1'b0; a3[i] = $urandom; d3[i] = $urandom; w3[i] = 4'($urandom);
                    end
                end
            end
            if (out_q) begin
                sr3 = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                sr3 = 1'($urandom_range(1));
            end
            sd3 = $urandom;
            #3;
            exp3 = '0;
            if (out_q) begin
                check("rnd_sreq", bus3.s_req, cap);
                check("rnd_busy", bus3.busy, 1'b1);
                if (sr3) exp3[cur*33 +: 33] = {sd3, 1'b1};
            end else begin
                check("rnd_sreq_idle", bus3.s_req, 69'h0);
                check("rnd_busy_idle", bus3.busy, 1'b0);
            end
            check("rnd_resp", bus3.m_resp, exp3);

            if (out_q) begin
                if (sr3) begin
                    out_q = 1'b0; pend[cur] = 1'b0; last_g = cur;
                end
            end else begin
                w = -1;
                for (int k = 0; k < 3; k++) begin
`ifdef IOB_MERGE_RR_FIXED_PRIO_EN
                    idx = k;
`else
                    idx = (last_g + 1 + k) % 3;
`endif
                    if (w < 0 && pend[idx]) w = idx;
                end
                if (w >= 0) begin
`ifndef IOB_MERGE_RR_FIXED_PRIO_EN
                    check("rnd_starve", waited[w] < 3, 1'b1);
`endif
                    for (int i = 0; i < 3; i++) if (pend[i] && i != w) waited[i]++;
                    out_q = 1'b1; cur = w; cap = {1'b1, a3[w], d3[w], w3[w]};
                    lat = $urandom_range(3);
                end
            end
        end

        step();
        for (int i = 0; i < 3; i++) v3[i] = 1'b0;
        sr3 = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
